fan_speed_controller: RTL and testbench



---
 rtl/fan_speed_controller.sv | 142 ++++++++++++++
 tb/tb_fan_speed_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_speed_controller.sv
// rtl/fan_speed_controller.sv - fan speed FSM with ms prescaler, auto-off countdown and motor PWM
module fan_speed_controller #(
   parameter int CLK_DIV        = 100000,
   parameter int PWM_PERIOD     = 1000,
   parameter int AUTO_OFF_TICKS = 10000
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_off,
   input  logic       i_btn_timer,
   output logic [2:0] o_fanState,
   output logic       o_pwm,
   output logic       o_timerActive
);

   localparam int PW      = $clog2(CLK_DIV);
   localparam int CW      = $clog2(AUTO_OFF_TICKS + 1);
   localparam int MW      = $clog2(PWM_PERIOD);
   localparam int TW      = $clog2(PWM_PERIOD + 1);
   localparam int QUARTER = PWM_PERIOD / 4;

   localparam logic [2:0] S_OFF = 3'd0;
   localparam logic [2:0] S_LV4 = 3'd4;

   logic [2:0]    r_state;
   logic [2:0]    w_next_state;
   logic          r_btn_up_prev;
   logic          r_btn_down_prev;
   logic          r_btn_off_prev;
   logic          r_btn_timer_prev;
   logic [PW-1:0] r_presc;
   logic [CW-1:0] r_countdown;
   logic          r_timer_active;
   logic [MW-1:0] r_pwm_cnt;
   logic [TW-1:0] r_thresh;
   logic          r_pwm;

   logic          w_press_up;
   logic          w_press_down;
   logic          w_press_off;
   logic          w_press_timer;
   logic          w_tick;
   logic          w_expire;
   logic          w_pwm_wrap;
   logic [TW-1:0] w_level_thresh;

   assign w_press_up     = i_btn_up    & ~r_btn_up_prev;
   assign w_press_down   = i_btn_down  & ~r_btn_down_prev;
   assign w_press_off    = i_btn_off   & ~r_btn_off_prev;
   assign w_press_timer  = i_btn_timer & ~r_btn_timer_prev;
   assign w_tick         = (r_presc == PW'(CLK_DIV - 1));
   // The tick that would take the countdown from 1 to 0 is the expiry event.
   assign w_expire       = r_timer_active & w_tick & (r_countdown == CW'(1));
   assign w_pwm_wrap     = (r_pwm_cnt == MW'(PWM_PERIOD - 1));
   assign w_level_thresh = TW'(32'(r_state) * QUARTER);

   // Button history for rising-edge detection
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_btn_up_prev    <= 1'b0;
         r_btn_down_prev  <= 1'b0;
         r_btn_off_prev   <= 1'b0;
         r_btn_timer_prev <= 1'b0;
      end else begin
         r_btn_up_prev    <= i_btn_up;
         r_btn_down_prev  <= i_btn_down;
         r_btn_off_prev   <= i_btn_off;
         r_btn_timer_prev <= i_btn_timer;
      end
   end

   // Fan state register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_OFF;
      else            r_state <= w_next_state;
   end

   // Next state: off press and timer expiry beat up, up beats down
   always_comb begin
      w_next_state = r_state;
      if (w_press_off || w_expire)                  w_next_state = S_OFF;
      else if (w_press_up && r_state != S_LV4)      w_next_state = r_state + 3'd1;
      else if (w_press_down && r_state != S_OFF)    w_next_state = r_state - 3'd1;
   end

   // State outputs
   always_comb begin
      o_fanState    = r_state;
      o_timerActive = r_timer_active;
      o_pwm         = r_pwm;
   end

   // Free-running millisecond prescaler
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)  r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + PW'(1);
   end

   // Auto-off arm/disarm and countdown; any move to OFF disarms
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_timer_active <= 1'b0;
         r_countdown    <= '0;
      end else if (w_next_state == S_OFF) begin
         r_timer_active <= 1'b0;
      end else if (w_press_timer) begin
         if (r_timer_active) begin
            r_timer_active <= 1'b0;
         end else if (r_state != S_OFF) begin
            r_timer_active <= 1'b1;
            r_countdown    <= CW'(AUTO_OFF_TICKS);
         end
      end else if (r_timer_active && w_tick) begin
         r_countdown <= r_countdown - CW'(1);
      end
   end

   // PWM period counter
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)      r_pwm_cnt <= '0;
      else if (w_pwm_wrap) r_pwm_cnt <= '0;
      else                 r_pwm_cnt <= r_pwm_cnt + MW'(1);
   end

   // Duty latched at period boundary; OFF forces the output low immediately
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_thresh <= '0;
         r_pwm    <= 1'b0;
      end else if (r_state == S_OFF) begin
         r_thresh <= '0;
         r_pwm    <= 1'b0;
      end else begin
         r_pwm <= (TW'(r_pwm_cnt) < r_thresh);
         if (w_pwm_wrap) r_thresh <= w_level_thresh;
      end
   end

endmodule

// File: tb/tb_fan_speed_controller.sv
// tb/tb_fan_speed_controller.sv - self-checking bench for fan_speed_controller
module tb_fan_speed_controller;

   localparam int CLK_DIV        = 4;
   localparam int PWM_PERIOD     = 8;
   localparam int AUTO_OFF_TICKS = 5;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic [3:0] btn;   // {timer, off, down, up}
   logic [2:0] fan_state;
   logic       pwm;
   logic       timer_active;

   int checks;
   int errors;
   bit model_valid;

   fan_speed_controller #(
      .CLK_DIV(CLK_DIV), .PWM_PERIOD(PWM_PERIOD), .AUTO_OFF_TICKS(AUTO_OFF_TICKS)
   ) dut (
      .i_clk(clk),
      .i_reset_n(rst_n),
      .i_btn_up(btn[0]),
      .i_btn_down(btn[1]),
      .i_btn_off(btn[2]),
      .i_btn_timer(btn[3]),
      .o_fanState(fan_state),
      .o_pwm(pwm),
      .o_timerActive(timer_active)
   );

   initial begin
      clk = 1'b0;
      forever #5 if (clk_en) clk = ~clk;
   end

   // Behavioural model: integer state, arithmetic rules
   int m_state, m_active, m_cd, m_ms, m_phase, m_duty, m_pwm;
   bit p_up, p_dn, p_off, p_tmr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_active = 0; m_cd = 0; m_ms = 0;
         m_phase = 0; m_duty = 0; m_pwm = 0;
         p_up = 0; p_dn = 0; p_off = 0; p_tmr = 0;
      end else begin
         bit up, dn, off, tmr, tick;
         int ns, na, ncd, nduty, npwm;
         up  = btn[0] && !p_up;
         dn  = btn[1] && !p_dn;
         off = btn[2] && !p_off;
         tmr = btn[3] && !p_tmr;
         tick = (m_ms == CLK_DIV - 1);
         ns = m_state;
         if (off || (m_active != 0 && tick && m_cd == 1)) ns = 0;
         else if (up)   ns = (m_state + 1 > 4) ? 4 : m_state + 1;
         else if (dn)   ns = (m_state - 1 < 0) ? 0 : m_state - 1;
         na = m_active; ncd = m_cd;
         if (ns == 0) na = 0;
         else if (tmr) begin
            if (m_active != 0) na = 0;
            else if (m_state != 0) begin na = 1; ncd = AUTO_OFF_TICKS; end
         end else if (m_active != 0 && tick) ncd = m_cd - 1;
         if (m_state == 0) begin
            nduty = 0; npwm = 0;
         end else begin
            npwm  = (m_phase < m_duty) ? 1 : 0;
            nduty = (m_phase == PWM_PERIOD - 1) ? m_state * PWM_PERIOD / 4 : m_duty;
         end
         m_state = ns; m_active = na; m_cd = ncd; m_duty = nduty; m_pwm = npwm;
         m_ms = (m_ms + 1) % CLK_DIV;
         m_phase = (m_phase + 1) % PWM_PERIOD;
         p_up = btn[0]; p_dn = btn[1]; p_off = btn[2]; p_tmr = btn[3];
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (model_valid) begin
         checks = checks + 3;
         if (int'(fan_state) != m_state) begin
            errors++;
            $display("FAIL model_state t=%0t got %0d exp %0d", $time, fan_state, m_state);
         end
         if (int'(timer_active) != m_active) begin
            errors++;
            $display("FAIL model_timer t=%0t got %0d exp %0d", $time, timer_active, m_active);
         end
         if (int'(pwm) != m_pwm) begin
            errors++;
            $display("FAIL model_pwm t=%0t got %0d exp %0d", $time, pwm, m_pwm);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle pulse; returns 1 ns after the edge that samples it
   task automatic pulse(input logic [3:0] m);
      @(posedge clk); #1 btn = m;
      @(posedge clk); #1 btn = 4'b0000;
   endtask

   task automatic count_high(output int h);
      h = 0;
      repeat (PWM_PERIOD) begin
         @(negedge clk);
         h += int'(pwm);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_state"}, int'(fan_state), 0);
      chk({name, "_pwm"}, int'(pwm), 0);
      chk({name, "_timer"}, int'(timer_active), 0);
   endtask

   int exp_up[5] = '{1, 2, 3, 4, 4};
   int exp_dn[5] = '{3, 2, 1, 0, 0};
   int h, n;

   initial begin
      checks = 0; errors = 0; model_valid = 0;
      clk_en = 0; rst_n = 1; btn = 4'b0000;

      // Reset with clock stopped
      #2 rst_n = 0;
      #1 model_valid = 1;
      chk_all_zero("reset_noclk");
      clk_en = 1;
      idle(3);
      rst_n = 1;
      idle(3);
      chk_all_zero("after_release");

      // Up steps and saturation
      for (int i = 0; i < 5; i++) begin
         pulse(4'b0001);
         chk($sformatf("up_%0d", i), int'(fan_state), exp_up[i]);
         idle(2);
      end
      pulse(4'b0100);
      chk("off_from4", int'(fan_state), 0);

      // Held up gives one step
      @(posedge clk); #1 btn = 4'b0001;
      idle(10);
      btn = 4'b0000;
      chk("up_held", int'(fan_state), 1);
      idle(2);

      // Down steps and floor
      repeat (3) begin pulse(4'b0001); idle(2); end
      for (int i = 0; i < 5; i++) begin
         pulse(4'b0010);
         chk($sformatf("down_%0d", i), int'(fan_state), exp_dn[i]);
         idle(2);
      end

      // PWM duty at levels 2, 3, 4 then off
      repeat (2) begin pulse(4'b0001); idle(2); end
      idle(16);
      count_high(h);
      chk("pwm_lv2_high", h, 4);
      idle(3);
      pulse(4'b0001);
      idle(16);
      count_high(h);
      chk("pwm_lv3_high", h, 6);
      pulse(4'b0001);
      idle(16);
      count_high(h);
      chk("pwm_lv4_high", h, 8);
      pulse(4'b0100);
      idle(1);
      chk("pwm_after_off", int'(pwm), 0);

      // Auto-off expiry
      repeat (3) begin pulse(4'b0001); idle(2); end
      pulse(4'b1000);
      chk("timer_armed", int'(timer_active), 1);
      n = 0;
      while (fan_state != 3'd0 && n < 40) begin
         idle(1);
         n++;
      end
      chk("expire_window", int'(n >= 16 && n <= 20), 1);
      chk("expire_timer", int'(timer_active), 0);

      // Timer cancelled before expiry
      repeat (3) begin pulse(4'b0001); idle(2); end
      pulse(4'b1000);
      idle(4);
      pulse(4'b1000);
      chk("timer_cancel", int'(timer_active), 0);
      idle(30);
      chk("cancel_level", int'(fan_state), 3);

      // Simultaneous presses
      pulse(4'b0100);
      repeat (2) begin pulse(4'b0001); idle(2); end
      pulse(4'b0101);
      chk("off_and_up", int'(fan_state), 0);
      pulse(4'b1000);
      chk("timer_while_off", int'(timer_active), 0);
      repeat (2) begin pulse(4'b0001); idle(2); end
      pulse(4'b0011);
      chk("up_and_down", int'(fan_state), 3);

      // Async reset mid-period with timer running
      pulse(4'b1000);
      chk("timer_armed2", int'(timer_active), 1);
      idle(3);
      @(negedge clk); #2 rst_n = 0;
      #1 chk_all_zero("reset_async");
      idle(2);
      rst_n = 1;
      repeat (3) begin pulse(4'b0001); idle(2); end
      idle(40);
      chk("no_spurious_off", int'(fan_state), 3);
      chk("no_spurious_timer", int'(timer_active), 0);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
